// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl_pkg
// Brief    : Shared types and encodings for the pipeline hazard controller.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MDU_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REG         = 2'b00;
    localparam logic [1:0] FWD_WB          = 2'b01;
    localparam logic [1:0] FWD_MEM         = 2'b10;
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : forward_unit
// Brief    : Operand bypass select for one E-stage source register.
// Revision : 1.0 - initial release
// ============================================================================
module forward_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] forward_sel
);

    // M is younger than W, so its result wins when both match.
    always_comb begin
        forward_sel = FWD_REG;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            forward_sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            forward_sel = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Stall/flush/forward control for the 5-stage pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_LATENCY = 32,
    parameter int CNT_W       = $clog2(MDU_LATENCY)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic [1:0] result_src_e,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    input  logic       pc_src_e,
    input  logic       mdu_start_e,
    input  logic       dmem_req_m,
    input  logic       dmem_ready,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       stall_m,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       flush_w,
    output logic [1:0] forward_a_e,
    output logic [1:0] forward_b_e,
    output logic       mdu_busy,
    output logic       mdu_done
);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_next_count;

    logic w_mem_wait;
    logic w_load_use;
    logic w_stall_f, w_stall_d, w_stall_e, w_stall_m;
    logic w_flush_d, w_flush_e, w_flush_m, w_flush_w;
    logic w_mdu_busy, w_mdu_done;
    logic [1:0] w_fwd_a, w_fwd_b;

    forward_unit u_fwd_a (
        .rs_e        (rs1_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .forward_sel (w_fwd_a)
    );

    forward_unit u_fwd_b (
        .rs_e        (rs2_e),
        .rd_m        (rd_m),
        .rd_w        (rd_w),
        .reg_write_m (reg_write_m),
        .reg_write_w (reg_write_w),
        .forward_sel (w_fwd_b)
    );

    assign w_mem_wait = dmem_req_m && !dmem_ready;
    assign w_load_use = (result_src_e == RESULT_SRC_LOAD) && (rd_e != 5'd0) &&
                        ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
        end
    end

    // A branch seen while E is frozen is only honoured in the release cycle,
    // when the branch instruction is allowed to leave E.
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_stall_f    = 1'b0;
        w_stall_d    = 1'b0;
        w_stall_e    = 1'b0;
        w_stall_m    = 1'b0;
        w_flush_d    = 1'b0;
        w_flush_e    = 1'b0;
        w_flush_m    = 1'b0;
        w_flush_w    = 1'b0;
        w_mdu_busy   = 1'b0;
        w_mdu_done   = 1'b0;

        case (r_state)
            RUN: begin
                if (w_mem_wait) begin
                    w_stall_f    = 1'b1;
                    w_stall_d    = 1'b1;
                    w_stall_e    = 1'b1;
                    w_stall_m    = 1'b1;
                    w_flush_w    = 1'b1;
                    w_next_state = MEM_WAIT;
                end else if (mdu_start_e) begin
                    w_stall_f    = 1'b1;
                    w_stall_d    = 1'b1;
                    w_stall_e    = 1'b1;
                    w_flush_m    = 1'b1;
                    w_mdu_busy   = 1'b1;
                    w_next_state = MDU_WAIT;
                    w_next_count = CNT_W'(MDU_LATENCY - 2);
                end else if (pc_src_e) begin
                    w_flush_d = 1'b1;
                    w_flush_e = 1'b1;
                end else if (w_load_use) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_flush_e = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    w_stall_f = 1'b1;
                    w_stall_d = 1'b1;
                    w_stall_e = 1'b1;
                    w_stall_m = 1'b1;
                    w_flush_w = 1'b1;
                end else begin
                    w_flush_d    = pc_src_e;
                    w_flush_e    = pc_src_e;
                    w_next_state = RUN;
                end
            end
            MDU_WAIT: begin
                w_mdu_busy = 1'b1;
                if (r_count != '0) begin
                    w_stall_f    = 1'b1;
                    w_stall_d    = 1'b1;
                    w_stall_e    = 1'b1;
                    w_flush_m    = 1'b1;
                    w_next_count = r_count - CNT_W'(1);
                end else begin
                    w_mdu_done   = 1'b1;
                    w_flush_d    = pc_src_e;
                    w_flush_e    = pc_src_e;
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = RUN;
                w_next_count = '0;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is held.
    assign stall_f     = rst_n & w_stall_f;
    assign stall_d     = rst_n & w_stall_d;
    assign stall_e     = rst_n & w_stall_e;
    assign stall_m     = rst_n & w_stall_m;
    assign flush_d     = rst_n & w_flush_d;
    assign flush_e     = rst_n & w_flush_e;
    assign flush_m     = rst_n & w_flush_m;
    assign flush_w     = rst_n & w_flush_w;
    assign mdu_busy    = rst_n & w_mdu_busy;
    assign mdu_done    = rst_n & w_mdu_done;
    assign forward_a_e = rst_n ? w_fwd_a : FWD_REG;
    assign forward_b_e = rst_n ? w_fwd_b : FWD_REG;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed and randomized checks of hazard_ctrl against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int LAT_A = 4;
    localparam int LAT_B = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic [1:0] result_src_e;
    logic       reg_write_m, reg_write_w, pc_src_e, mdu_start_e, dmem_req_m, dmem_ready;

    logic       a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_fw, a_busy, a_done;
    logic [1:0] a_fa, a_fb;
    logic       b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_fw, b_busy, b_done;
    logic [1:0] b_fa, b_fb;

    // Output bundle: {stall f,d,e,m, flush d,e,m,w, fwd_a, fwd_b, busy, done}
    logic [13:0] got_a, got_b;
    assign got_a = {a_sf, a_sd, a_se, a_sm, a_fd, a_fe, a_fm, a_fw, a_fa, a_fb, a_busy, a_done};
    assign got_b = {b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fm, b_fw, b_fa, b_fb, b_busy, b_done};

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles the MDU op has been in E (0 = none),
    // and whether a memory access is outstanding.
    int m_age  = 0;
    bit m_hold = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MDU_LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .result_src_e(result_src_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
        .mdu_start_e(mdu_start_e), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .stall_f(a_sf), .stall_d(a_sd), .stall_e(a_se), .stall_m(a_sm),
        .flush_d(a_fd), .flush_e(a_fe), .flush_m(a_fm), .flush_w(a_fw),
        .forward_a_e(a_fa), .forward_b_e(a_fb), .mdu_busy(a_busy), .mdu_done(a_done)
    );

    hazard_ctrl #(.MDU_LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .result_src_e(result_src_e),
        .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
        .mdu_start_e(mdu_start_e), .dmem_req_m(dmem_req_m), .dmem_ready(dmem_ready),
        .stall_f(b_sf), .stall_d(b_sd), .stall_e(b_se), .stall_m(b_sm),
        .flush_d(b_fd), .flush_e(b_fe), .flush_m(b_fm), .flush_w(b_fw),
        .forward_a_e(b_fa), .forward_b_e(b_fb), .mdu_busy(b_busy), .mdu_done(b_done)
    );

    task automatic idle();
        rs1_d = 5'd0; rs2_d = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0; result_src_e = 2'b00;
        reg_write_m = 1'b0; reg_write_w = 1'b0; pc_src_e = 1'b0;
        mdu_start_e = 1'b0; dmem_req_m = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
        if (rs != 5'd0 && reg_write_m && rd_m == rs) return 2'b10;
        if (rs != 5'd0 && reg_write_w && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [13:0] model_expect();
        logic [7:0] sf;   // {stall f,d,e,m, flush d,e,m,w}
        logic busy, done, lu;
        sf = 8'h00; busy = 1'b0; done = 1'b0;
        lu = (result_src_e == 2'b01) && (rd_e != 5'd0) && (rd_e == rs1_d || rd_e == rs2_d);
        if (m_age > 0) begin
            busy = 1'b1;
            if (m_age < LAT_A) sf = 8'b1110_0010;
            else begin
                done = 1'b1;
                if (pc_src_e) sf = 8'b0000_1100;
            end
        end else if (m_hold) begin
            if (!dmem_ready) sf = 8'b1111_0001;
            else if (pc_src_e) sf = 8'b0000_1100;
        end else if (dmem_req_m && !dmem_ready) begin
            sf = 8'b1111_0001;
        end else if (mdu_start_e) begin
            sf = 8'b1110_0010; busy = 1'b1;
        end else if (pc_src_e) begin
            sf = 8'b0000_1100;
        end else if (lu) begin
            sf = 8'b1100_0100;
        end
        return {sf, fwd_ref(rs1_e), fwd_ref(rs2_e), busy, done};
    endfunction

    task automatic model_advance();
        if (m_age > 0) m_age = (m_age >= LAT_A) ? 0 : m_age + 1;
        else if (m_hold) m_hold = !dmem_ready;
        else if (dmem_req_m && !dmem_ready) m_hold = 1'b1;
        else if (mdu_start_e) m_age = 2;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        mdu_start_e = 1'b1; reg_write_m = 1'b1; rd_m = 5'd3; rs1_e = 5'd3;
        #1;
        checks++;
        if (got_a !== 14'h0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", got_a, 14'h0);
        end
        idle();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (got_a !== 14'h0) begin
            errors++; $display("FAIL reset_idle got=%h exp=%h", got_a, 14'h0);
        end
    endtask

    task automatic test_forwarding();
        idle();
        rd_m = 5'd5; reg_write_m = 1'b1; rs1_e = 5'd5; rd_w = 5'd5; reg_write_w = 1'b1;
        rs2_e = 5'd5;
        #1;
        checks++;
        if (a_fa !== 2'b10 || a_fb !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_prio got=%b/%b exp=10/10", a_fa, a_fb);
        end
        reg_write_m = 1'b0;
        #1;
        checks++;
        if (a_fa !== 2'b01) begin
            errors++; $display("FAIL fwd_wb got=%b exp=01", a_fa);
        end
        rd_m = 5'd0; rd_w = 5'd0; rs1_e = 5'd0; reg_write_m = 1'b1;
        #1;
        checks++;
        if (a_fa !== 2'b00) begin
            errors++; $display("FAIL fwd_x0 got=%b exp=00", a_fa);
        end
        idle();
    endtask

    task automatic test_load_use();
        idle();
        tick();
        result_src_e = 2'b01; rd_e = 5'd7; rs2_d = 5'd7;
        #1;
        checks++;
        if (got_a[13:6] !== 8'b1100_0100) begin
            errors++; $display("FAIL load_use got=%b exp=11000100", got_a[13:6]);
        end
        tick();
        result_src_e = 2'b00; rd_e = 5'd0;
        #1;
        checks++;
        if (got_a[13:6] !== 8'h00) begin
            errors++; $display("FAIL load_use_one_cycle got=%b exp=00000000", got_a[13:6]);
        end
        result_src_e = 2'b01; rd_e = 5'd7; pc_src_e = 1'b1;
        #1;
        checks++;
        if (got_a[13:6] !== 8'b0000_1100) begin
            errors++; $display("FAIL load_use_branch got=%b exp=00001100", got_a[13:6]);
        end
        idle();
    endtask

    task automatic test_mdu();
        idle();
        tick();
        mdu_start_e = 1'b1;
        for (int i = 0; i < LAT_A - 1; i++) begin
            #1;
            checks++;
            if ({got_a[13:6], got_a[1:0]} !== 10'b1110_0010_10) begin
                errors++; $display("FAIL mdu_stall cyc=%0d got=%b exp=1110001010", i, {got_a[13:6], got_a[1:0]});
            end
            tick();
        end
        #1;
        checks++;
        if ({got_a[13:6], got_a[1:0]} !== 10'b0000_0000_11) begin
            errors++; $display("FAIL mdu_done got=%b exp=0000000011", {got_a[13:6], got_a[1:0]});
        end
        tick();
        mdu_start_e = 1'b0;
        #1;
        checks++;
        if ({got_a[13:6], got_a[1:0]} !== 10'b0) begin
            errors++; $display("FAIL mdu_no_retrigger got=%b exp=0", {got_a[13:6], got_a[1:0]});
        end
        idle();
    endtask

    task automatic test_mem_wait(input bit branch);
        idle();
        tick();
        dmem_req_m = 1'b1; dmem_ready = 1'b0; pc_src_e = branch;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (got_a[13:6] !== 8'b1111_0001) begin
                errors++; $display("FAIL mem_wait br=%0d cyc=%0d got=%b exp=11110001", branch, i, got_a[13:6]);
            end
            tick();
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (got_a[13:6] !== (branch ? 8'b0000_1100 : 8'h00)) begin
            errors++; $display("FAIL mem_release br=%0d got=%b exp=%b", branch, got_a[13:6],
                               branch ? 8'b0000_1100 : 8'h00);
        end
        tick();
        idle();
    endtask

    task automatic test_reset_mid_mdu();
        idle();
        tick();
        mdu_start_e = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        checks++;
        if (b_sf !== 1'b1 || b_busy !== 1'b1) begin
            errors++; $display("FAIL mdu32_midway got stall_f=%b busy=%b exp 1/1", b_sf, b_busy);
        end
        reg_write_m = 1'b1; rd_m = 5'd9; rs1_e = 5'd9;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (got_b !== 14'h0) begin
            errors++; $display("FAIL mdu32_async_reset got=%h exp=%h", got_b, 14'h0);
        end
        idle();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (got_b !== 14'h0 || got_a !== 14'h0) begin
                errors++; $display("FAIL post_reset_idle cyc=%0d got32=%h got4=%h exp=0", i, got_b, got_a);
            end
        end
    endtask

    task automatic test_random();
        logic [13:0] exp;
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_age = 0; m_hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            result_src_e = 2'($urandom_range(0, 3));
            reg_write_m  = 1'($urandom_range(0, 1));
            reg_write_w  = 1'($urandom_range(0, 1));
            pc_src_e     = ($urandom_range(0, 5) == 0);
            mdu_start_e  = ($urandom_range(0, 7) == 0);
            dmem_req_m   = ($urandom_range(0, 3) == 0);
            dmem_ready   = 1'($urandom_range(0, 1));
            #2;
            exp = model_expect();
            checks++;
            if (got_a !== exp) begin
                errors++; $display("FAIL random cyc=%0d got=%b exp=%b", i, got_a, exp);
            end
            model_advance();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mdu();
        test_mem_wait(1'b0);
        test_mem_wait(1'b1);
        test_reset_mid_mdu();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
